// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-transfer master bridge.
// Accepts one valid/ready request at a time, runs a registered classic cycle,
// and returns read data or an error/timeout over a valid/ready response port.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_data,
    input  logic [3:0]  i_req_sel,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_err
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_to_q, rsp_to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and output registers; reset clears everything and drops any cycle in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, terminate on err > ack > watchdog in BUS, hand off in RESP.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_we ? i_req_data : 32'h0;
                    sel_d   = i_req_sel;
                    cnt_d   = '0;
                end
            end
            ST_BUS: begin
                if (i_wb_err) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                    rsp_data_d  = 32'h0;
                end else if (i_wb_ack) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    rsp_data_d  = we_q ? 32'h0 : i_wb_data;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_data_d  = 32'h0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request side is ready only when idle and out of reset.
    assign o_req_ready   = (state_q == ST_IDLE) && i_rst_n;

    // cyc and stb share one register so they can never disagree.
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = cyc_q;
    assign o_wb_we       = we_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_data     = wdata_q;
    assign o_wb_sel      = sel_q;
    assign o_wb_cti      = 3'b000;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Testbench for wb_master_bridge: directed vector table, random transfers
// checked against a transaction-level model, and reset corner sequences.
module tb_wb_master_bridge;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_sel;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;
    logic        i_wb_err;

    always #5 clk = ~clk;

    wb_master_bridge #(.TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .i_req_sel     (i_req_sel),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_data     (o_wb_data),
        .o_wb_sel      (o_wb_sel),
        .o_wb_cti      (o_wb_cti),
        .i_wb_ack      (i_wb_ack),
        .i_wb_data     (i_wb_data),
        .i_wb_err      (i_wb_err)
    );

    // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = slave silent
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int unsigned wait_n;
        int unsigned kind;
        int unsigned rdly;
        int unsigned exp_stb;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[8];

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input logic [31:0] rdata,
                                input int unsigned w, input int unsigned k, input int unsigned d,
                                input int unsigned es, input logic [31:0] ed,
                                input logic ee, input logic eto);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.rdata = rdata;
        v.wait_n = w; v.kind = k; v.rdly = d;
        v.exp_stb = es; v.exp_data = ed; v.exp_err = ee; v.exp_to = eto;
        return v;
    endfunction

    // Transaction-level reference: what the slave's behaviour implies for one transfer.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.kind == 3 || v.wait_n + 1 > TO) begin
            r.exp_stb = TO; r.exp_data = 32'h0; r.exp_err = 1'b1; r.exp_to = 1'b1;
        end else begin
            r.exp_stb = v.wait_n + 1;
            r.exp_to  = 1'b0;
            if (v.kind != 0) begin
                r.exp_err = 1'b1; r.exp_data = 32'h0;
            end else begin
                r.exp_err = 1'b0; r.exp_data = v.we ? 32'h0 : v.rdata;
            end
        end
        return r;
    endfunction

    task automatic check_inv();
        chk1("cyc_eq_stb", o_wb_cyc, o_wb_stb);
        chk1("rsp_and_cyc_exclusive", o_wb_cyc & o_rsp_valid, 1'b0);
        chk32("cti_classic", 32'(o_wb_cti), 32'h0);
    endtask

    // Issue one request, play the slave, hold off the response, then consume it.
    task automatic run_txn(input vec_t v);
        int  stb_n;
        bit  done;
        logic [31:0] exp_wd;
        exp_wd = v.we ? v.wdata : 32'h0;
        chk1("req_ready_idle", o_req_ready, 1'b1);
        i_req_valid = 1'b1;
        i_req_we    = v.we;
        i_req_addr  = v.addr;
        i_req_data  = v.wdata;
        i_req_sel   = v.sel;
        step();
        i_req_valid = 1'b0;
        i_req_we    = ~v.we;
        i_req_addr  = $urandom;
        i_req_data  = $urandom;
        i_req_sel   = 4'($urandom);
        stb_n = 0;
        done  = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (o_wb_cyc) begin
                stb_n++;
                chk1("wb_we_stable", o_wb_we, v.we);
                chk32("wb_addr_stable", o_wb_addr, v.addr);
                chk32("wb_data_stable", o_wb_data, exp_wd);
                chk32("wb_sel_stable", 32'(o_wb_sel), 32'(v.sel));
                chk1("req_ready_bus", o_req_ready, 1'b0);
                check_inv();
                i_wb_data = $urandom;
                if (v.kind != 3 && stb_n == int'(v.wait_n) + 1) begin
                    i_wb_ack  = (v.kind != 1);
                    i_wb_err  = (v.kind != 0);
                    i_wb_data = v.rdata;
                end
                step();
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL stb_bound: cycle still open after 300 cycles");
        end
        chk32("stb_cycles", 32'(stb_n), 32'(v.exp_stb));
        for (int d = 0; d < int'(v.rdly); d++) begin
            chk1("rsp_valid_hold", o_rsp_valid, 1'b1);
            chk32("rsp_data_hold", o_rsp_data, v.exp_data);
            chk1("rsp_err_hold", o_rsp_err, v.exp_err);
            chk1("rsp_to_hold", o_rsp_timeout, v.exp_to);
            chk1("req_ready_resp", o_req_ready, 1'b0);
            check_inv();
            i_req_valid = 1'b1;
            i_req_addr  = $urandom;
            step();
            chk1("no_accept_in_resp", o_wb_cyc, 1'b0);
        end
        i_req_valid = 1'b0;
        chk1("rsp_valid", o_rsp_valid, 1'b1);
        chk32("rsp_data", o_rsp_data, v.exp_data);
        chk1("rsp_err", o_rsp_err, v.exp_err);
        chk1("rsp_timeout", o_rsp_timeout, v.exp_to);
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        chk1("rsp_valid_cleared", o_rsp_valid, 1'b0);
        chk1("rsp_err_cleared", o_rsp_err, 1'b0);
        chk1("rsp_to_cleared", o_rsp_timeout, 1'b0);
        chk1("req_ready_after", o_req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = mk(1'b0, 32'h84, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 32'h04, 32'h5, 4'hF, 32'h11112222, 3, 0, 0, 4, 32'h0, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 32'h10, 32'h0, 4'h3, 32'hCAFEF00D, 1, 2, 1, 2, 32'h0, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 32'h20, 32'h0, 4'hF, 32'h0BADF00D, 0, 3, 0, 8, 32'h0, 1'b1, 1'b1);
        vecs[4] = mk(1'b0, 32'h24, 32'h0, 4'hF, 32'h12345678, 7, 0, 0, 8, 32'h12345678, 1'b0, 1'b0);
        vecs[5] = mk(1'b1, 32'h28, 32'hFFFF0000, 4'hC, 32'h55555555, 0, 1, 2, 1, 32'h0, 1'b1, 1'b0);
        vecs[6] = mk(1'b0, 32'h2C, 32'h0, 4'h1, 32'hA5A50F0F, 2, 0, 5, 3, 32'hA5A50F0F, 1'b0, 1'b0);
        vecs[7] = mk(1'b0, 32'h30, 32'h0, 4'hF, 32'h77777777, 8, 0, 0, 8, 32'h0, 1'b1, 1'b1);

        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0;
        i_req_data  = 32'h0;
        i_req_sel   = 4'h0;
        i_rsp_ready = 1'b0;
        i_wb_ack    = 1'b0;
        i_wb_err    = 1'b0;
        i_wb_data   = 32'h0;

        // Reset state
        step();
        step();
        chk1("rst_cyc", o_wb_cyc, 1'b0);
        chk1("rst_stb", o_wb_stb, 1'b0);
        chk1("rst_we", o_wb_we, 1'b0);
        chk32("rst_addr", o_wb_addr, 32'h0);
        chk32("rst_wdata", o_wb_data, 32'h0);
        chk32("rst_sel", 32'(o_wb_sel), 32'h0);
        chk1("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk32("rst_rsp_data", o_rsp_data, 32'h0);
        chk1("rst_rsp_err", o_rsp_err, 1'b0);
        chk1("rst_rsp_to", o_rsp_timeout, 1'b0);
        chk1("rst_req_ready_low", o_req_ready, 1'b0);
        i_rst_n = 1'b1;
        #1;
        chk1("rst_release_ready", o_req_ready, 1'b1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Randomized transfers against the reference model
        for (int i = 0; i < 24; i++) begin
            int unsigned k;
            v.we     = 1'($urandom_range(0, 1));
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.sel    = 4'($urandom);
            v.rdata  = $urandom;
            v.wait_n = $urandom_range(0, 10);
            k        = $urandom_range(0, 9);
            v.kind   = (k < 6) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 3;
            v.rdly   = $urandom_range(0, 3);
            run_txn(model(v));
        end

        // Reset in the middle of a bus cycle, then a stray ack while idle
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h100;
        i_req_sel   = 4'hF;
        step();
        i_req_valid = 1'b0;
        chk1("midrst_cyc_up", o_wb_cyc, 1'b1);
        step();
        chk1("midrst_cyc_up2", o_wb_cyc, 1'b1);
        i_rst_n = 1'b0;
        step();
        chk1("midrst_cyc", o_wb_cyc, 1'b0);
        chk1("midrst_stb", o_wb_stb, 1'b0);
        chk32("midrst_addr", o_wb_addr, 32'h0);
        chk1("midrst_rsp_valid", o_rsp_valid, 1'b0);
        i_rst_n = 1'b1;
        #1;
        chk1("midrst_ready", o_req_ready, 1'b1);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h13572468;
        step();
        chk1("stray_ack_no_rsp", o_rsp_valid, 1'b0);
        chk1("stray_ack_no_cyc", o_wb_cyc, 1'b0);
        step();
        i_wb_ack = 1'b0;
        chk1("stray_ack_no_rsp2", o_rsp_valid, 1'b0);
        chk1("stray_ack_ready", o_req_ready, 1'b1);

        // One more transfer to confirm normal operation after the reset
        run_txn(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic single-transfer master. Converts a simple valid/ready request/response interface from a core load/store unit or DMA into Wishbone B4 classic cycles toward slaves such as the interrupt controller, timers and UART.
- Registers all bus outputs.
- Reports bus errors and adds a watchdog timeout for slaves that never respond.

Parameters:
- TIMEOUT, 256: cycles to wait for ack/err after stb asserts before aborting. 0 disables the watchdog. Legal range 0..65535.

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  bridge idle, request accepted when valid&ready
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  32  byte address
- i_req_data  in  32  write data
- i_req_sel  in  4  byte lane select
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_data  out  32  read data; 0 for writes, errors and timeouts
- o_rsp_err  out  1  transfer ended with i_wb_err or timeout
- o_rsp_timeout  out  1  transfer ended by watchdog
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  Wishbone write enable
- o_wb_addr  out  32  Wishbone address
- o_wb_data  out  32  Wishbone write data
- o_wb_sel  out  4  Wishbone select
- o_wb_cti  out  3  always 3'b000 (classic)
- i_wb_ack  in  1  slave ack
- i_wb_data  in  32  slave read data
- i_wb_err  in  1  slave error

Interface rule: one clock (i_clk); reset i_rst_n is synchronous, active-low.

Behaviour:
- Reset (i_rst_n=0 at a rising edge), regardless of state:
  - state=IDLE.
  - o_wb_cyc/stb/we=0; o_wb_addr/data=0; o_wb_sel=0.
  - o_rsp_valid/err/timeout=0; o_rsp_data=0; watchdog counter=0.
  - Mid-transfer reset drops cyc/stb on that edge; the pending response is discarded.
- States: IDLE, BUS, RESP (2-bit encoding). o_req_ready = (state==IDLE) && i_rst_n, combinational.
- IDLE:
  - On valid&ready, latch we/addr/data/sel into the o_wb_* registers, set cyc=stb=1, counter=0, go to BUS.
  - For reads, o_wb_data is driven 0.
- BUS: o_wb_* stay stable until termination. Each cycle, in priority order:
  - i_wb_err=1 (even with ack=1): cyc=stb=0, rsp_err=1, rsp_data=0, rsp_timeout=0, go to RESP.
  - else i_wb_ack=1: cyc=stb=0, rsp_err=0; rsp_data = (we ? 0 : i_wb_data), captured this edge; go to RESP.
  - else if TIMEOUT!=0 and counter==TIMEOUT-1: cyc=stb=0, rsp_err=1, rsp_timeout=1, rsp_data=0, go to RESP.
  - else counter+1. Counter is 16 bits and saturates, never wraps.
- Ack or err arriving in the same cycle as the timeout wins; no timeout is flagged.
- RESP:
  - o_rsp_valid=1; data, err and timeout are held stable until i_rsp_ready=1.
  - On handshake: o_rsp_valid=0, err/timeout cleared, go to IDLE.
- i_wb_ack/i_wb_err outside BUS are ignored and produce no response.
- i_wb_cyc-style retries are not supported. A slave holding ack across cycles has no effect because stb is already low.
- Latency, with a combinational slave:
  - Request accepted at edge T; stb high during cycle T..T+1.
  - Ack sampled at edge T+1; stb low and rsp_valid high after T+1.
  - With i_rsp_ready tied 1, IDLE after T+2.
  - Minimum 3 cycles per transfer; no pipelining and no outstanding transfers beyond one.
- o_wb_cyc==o_wb_stb at all times.
- o_rsp_valid and o_wb_cyc are never both 1.

Test Plan:
- Read, slave acks in the first stb cycle with data 32'hDEADBEEF at addr 32'h84 → cyc/stb high exactly 1 cycle; o_rsp_valid next cycle; rsp_data=32'hDEADBEEF, err=0, timeout=0.
- Write 32'h0000_0005 to 32'h04, sel=4'hF, slave acks after 3 wait cycles → we/addr/data/sel stable for all 4 stb cycles; rsp_data=0, err=0.
- Slave asserts ack and err together on a read → rsp_err=1, rsp_data=0, rsp_timeout=0.
- TIMEOUT=8, slave silent → stb high exactly 8 cycles then drops; rsp_err=1, rsp_timeout=1. Repeat with ack on the 8th cycle → err=0, timeout=0.
- i_rsp_ready held low 5 cycles → rsp_valid/data stable, o_req_ready=0 throughout, new i_req_valid not accepted; accepted the cycle after the handshake.
- i_rst_n=0 during BUS on cycle 2 → cyc/stb=0 on the next edge, no response emitted; after release, o_req_ready=1 and a stray i_wb_ack produces no response.
